bin_to_bcd_seq: RTL and testbench

//   Sequential binary-to-BCD converter (shift-add-3 / double-dabble), one bit per clock.

---
 rtl/bin_to_bcd_seq.sv | 92 +++++++++
 tb/tb_bin_to_bcd_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-add-3 (double dabble), one input bit per clock.
// Start/busy/done handshake; bcd_out and ovf are held until the next completion or reset.
//
// state | meaning
// IDLE  | waiting for start; last result held on bcd_out/ovf
// SHIFT | one add-3 + shift iteration per clock, count bits remaining
module bin_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = 4 * DIGITS;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [SW-1:0]    scratch;
    logic [SW-1:0]    adj;
    logic [SW-1:0]    shifted;
    logic             carry;
    logic             ovf_acc;
    logic [CW-1:0]    count;

    // A digit is at most 9 before adjust, so +3 tops out at 12 and never wraps.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        {carry, shifted, shreg_next} = {adj, shreg, 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
            ovf     <= 1'b0;
            shreg   <= '0;
            scratch <= '0;
            ovf_acc <= 1'b0;
            count   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= bin_in;
                        scratch <= '0;
                        ovf_acc <= 1'b0;
                        count   <= CW'(WIDTH);
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= shifted;
                    shreg   <= shreg_next;
                    ovf_acc <= ovf_acc | carry;
                    count   <= count - 1'b1;
                    if (count == CW'(1)) begin
                        bcd_out <= shifted;
                        ovf     <= ovf_acc | carry;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: a 3-digit instance and a 2-digit (overflowing) instance share stimulus;
// expected results come from a decimal model and are queued at start, popped at done.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  bin_in;
    logic        busy, done, ovf;
    logic [11:0] bcd_out;
    logic        busy2, done2, ovf2;
    logic [7:0]  bcd2;

    typedef struct {
        logic [11:0] b3;
        logic [7:0]  b2;
        logic        o2;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [11:0] last3;
    logic [7:0]  last2;
    logic        lasto2;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .bcd_out(bcd_out), .ovf(ovf)
    );

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy2), .done(done2), .bcd_out(bcd2), .ovf(ovf2)
    );

    function automatic logic [11:0] dec(input int v, input int nd);
        logic [11:0] r;
        int          t;
        r = '0;
        t = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic push_exp(input int v);
        exp_t        e;
        logic [11:0] d2;
        d2   = dec(v, 2);
        e.b3 = dec(v, 3);
        e.b2 = d2[7:0];
        e.o2 = (v >= 100);
        q.push_back(e);
    endtask

    // Called #1 after an edge with the DUTs idle; returns #1 after the done edge
    // (or one edge later when check_pulse is set). ign_at injects an ignored start.
    task automatic run_conv(input int v, input bit check_pulse, input int ign_at);
        exp_t e;
        int   n;
        start  = 1'b1;
        bin_in = v[7:0];
        push_exp(v);
        @(posedge clk); #1;
        start  = 1'b0;
        bin_in = 8'($urandom);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            checks++;
            if (busy !== 1'b1 || busy2 !== 1'b1 || done2 !== 1'b0 ||
                bcd_out !== last3 || bcd2 !== last2 || ovf2 !== lasto2) begin
                errors++;
                $display("FAIL hold v=%0d n=%0d: busy=%b busy2=%b done2=%b bcd=%h/%h ovf2=%b expected busy=1 bcd=%h/%h ovf2=%b",
                         v, n, busy, busy2, done2, bcd_out, bcd2, ovf2, last3, last2, lasto2);
            end
            if (n == ign_at) begin
                start  = 1'b1;
                bin_in = 8'd7;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL latency v=%0d: got %0d edges, expected 8", v, n);
        end
        e = q.pop_front();
        checks++;
        if (bcd_out !== e.b3 || ovf !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL result3 v=%0d: got bcd=%h ovf=%b busy=%b, expected bcd=%h ovf=0 busy=0",
                     v, bcd_out, ovf, busy, e.b3);
        end
        checks++;
        if (done2 !== 1'b1 || busy2 !== 1'b0 || bcd2 !== e.b2 || ovf2 !== e.o2) begin
            errors++;
            $display("FAIL result2 v=%0d: got done=%b busy=%b bcd=%h ovf=%b, expected done=1 busy=0 bcd=%h ovf=%b",
                     v, done2, busy2, bcd2, ovf2, e.b2, e.o2);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bcd_out[4*i +: 4] > 4'd9) begin
                errors++;
                $display("FAIL digit v=%0d d%0d: got %h, expected <= 9", v, i, bcd_out[4*i +: 4]);
            end
        end
        last3  = e.b3;
        last2  = e.b2;
        lasto2 = e.o2;
        if (check_pulse) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || done2 !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL pulse v=%0d: got done=%b done2=%b busy=%b, expected 0 0 0",
                         v, done, done2, busy);
            end
        end
    endtask

    task automatic check_idle_zero(input string tag);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 12'h000 || ovf !== 1'b0 ||
            busy2 !== 1'b0 || done2 !== 1'b0 || bcd2 !== 8'h00 || ovf2 !== 1'b0) begin
            errors++;
            $display("FAIL %s: got busy=%b done=%b bcd=%h ovf=%b / busy2=%b done2=%b bcd2=%h ovf2=%b, expected all zero",
                     tag, busy, done, bcd_out, ovf, busy2, done2, bcd2, ovf2);
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        start  = 1'b1;
        bin_in = 8'd255;
        repeat (2) @(posedge clk);
        #1;
        check_idle_zero("reset");
        rst   = 1'b0;
        start = 1'b0;
        last3 = '0; last2 = '0; lasto2 = 1'b0;
        @(posedge clk); #1;
        check_idle_zero("reset_idle");
    endtask

    task automatic test_latency();
        run_conv(255, 1'b1, -1);
        run_conv(0, 1'b1, -1);
    endtask

    task automatic test_exhaustive();
        for (int v = 0; v < 256; v++) run_conv(v, 1'b1, -1);
    endtask

    task automatic test_back_to_back();
        run_conv(42, 1'b0, 2);
        run_conv(7, 1'b1, -1);
    endtask

    task automatic test_reset_midop();
        start  = 1'b1;
        bin_in = 8'd200;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_zero("midop_reset");
        last3 = '0; last2 = '0; lasto2 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || done2 !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midop_quiet cycle %0d: got done=%b done2=%b busy=%b, expected 0 0 0",
                         i, done, done2, busy);
            end
        end
        run_conv(13, 1'b1, -1);
    endtask

    task automatic test_overflow();
        run_conv(99, 1'b1, -1);
        run_conv(200, 1'b1, -1);
        run_conv(255, 1'b1, -1);
        run_conv(100, 1'b1, -1);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_exhaustive();
        test_back_to_back();
        test_reset_midop();
        test_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
